// File: rtl/radio_pkg.sv
// Shared definitions for the radio serial transceiver: FSM state encoding and
// serial line levels.
package radio_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } xcvr_state_e;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/radio_sync_fifo.sv
// Single-clock show-ahead FIFO for the TX path; writes are refused while full,
// even if a pop happens on the same cycle.
module radio_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/radio_serial_xcvr.sv
// Serial transceiver: FIFO-buffered TX framer, oversampling RX deframer, LEDs.
// Optional even parity bit enabled by defining RADIO_XCVR_PARITY_EN.
//
// state  | meaning
// IDLE   | line idle, waiting for a word (TX) or a low level (RX)
// START  | start bit (RX: mid-bit glitch check)
// DATA   | payload bits, LSB first
// PARITY | even parity bit (only with RADIO_XCVR_PARITY_EN)
// STOP   | stop bit (RX: deliver word or flag an error)
module radio_serial_xcvr
  import radio_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 16,
  parameter int LED_W        = 8
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              tx_serial_data,
  input  logic              rx_serial_data,
  output logic              err_framing,
  output logic              err_overrun,
  output logic              err_parity,
  output logic [LED_W-1:0]  led
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_W);
  localparam int CW = LED_W - 2;
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BIT_TOP   = BW'(DATA_W - 1);

  xcvr_state_e       tx_state;
  logic [TW-1:0]     tx_timer;
  logic [BW-1:0]     tx_bit;
  logic [DATA_W-1:0] tx_shift;
  logic              tx_ready_en;
  logic              tx_pop;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_full;
  logic              fifo_empty;
`ifdef RADIO_XCVR_PARITY_EN
  logic              tx_par;
`endif

  assign tx_ready = tx_ready_en && !fifo_full;
  assign tx_pop   = !fifo_empty &&
                    ((tx_state == IDLE) || (tx_state == STOP && tx_timer == '0));

  radio_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk     (clk_clk),
    .reset   (reset_reset),
    .wr_en   (tx_valid && tx_ready),
    .wr_data (tx_data),
    .rd_en   (tx_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      tx_state       <= IDLE;
      tx_serial_data <= IDLE_LEVEL;
      tx_timer       <= '0;
      tx_bit         <= '0;
      tx_shift       <= '0;
      tx_ready_en    <= 1'b0;
`ifdef RADIO_XCVR_PARITY_EN
      tx_par         <= 1'b0;
`endif
    end else begin
      tx_ready_en <= 1'b1;
      case (tx_state)
        IDLE: begin
          if (tx_pop) begin
            tx_state       <= START;
            tx_serial_data <= START_LEVEL;
            tx_timer       <= BIT_LAST;
            tx_shift       <= fifo_rd_data;
`ifdef RADIO_XCVR_PARITY_EN
            tx_par         <= ^fifo_rd_data;
`endif
          end
        end
        START: begin
          if (tx_timer == '0) begin
            tx_state       <= DATA;
            tx_serial_data <= tx_shift[0];
            tx_timer       <= BIT_LAST;
            tx_bit         <= BIT_TOP;
          end else begin
            tx_timer <= tx_timer - 1'b1;
          end
        end
        DATA: begin
          if (tx_timer == '0) begin
            tx_timer <= BIT_LAST;
            tx_shift <= tx_shift >> 1;
            if (tx_bit == '0) begin
`ifdef RADIO_XCVR_PARITY_EN
              tx_state       <= PARITY;
              tx_serial_data <= tx_par;
`else
              tx_state       <= STOP;
              tx_serial_data <= IDLE_LEVEL;
`endif
            end else begin
              tx_bit         <= tx_bit - 1'b1;
              tx_serial_data <= tx_shift[1];
            end
          end else begin
            tx_timer <= tx_timer - 1'b1;
          end
        end
        PARITY: begin
          if (tx_timer == '0) begin
            tx_state       <= STOP;
            tx_serial_data <= IDLE_LEVEL;
            tx_timer       <= BIT_LAST;
          end else begin
            tx_timer <= tx_timer - 1'b1;
          end
        end
        STOP: begin
          if (tx_timer == '0) begin
            // back-to-back frames: reload straight into START without an idle bit
            if (tx_pop) begin
              tx_state       <= START;
              tx_serial_data <= START_LEVEL;
              tx_timer       <= BIT_LAST;
              tx_shift       <= fifo_rd_data;
`ifdef RADIO_XCVR_PARITY_EN
              tx_par         <= ^fifo_rd_data;
`endif
            end else begin
              tx_state       <= IDLE;
              tx_serial_data <= IDLE_LEVEL;
            end
          end else begin
            tx_timer <= tx_timer - 1'b1;
          end
        end
        default: begin
          tx_state       <= IDLE;
          tx_serial_data <= IDLE_LEVEL;
        end
      endcase
    end
  end

  logic              rx_s1;
  logic              rx_s2;
  xcvr_state_e       rx_state;
  logic [TW-1:0]     rx_timer;
  logic [BW-1:0]     rx_bit;
  logic [DATA_W-1:0] rx_shift;
  logic              rx_wait;
  logic [CW-1:0]     rx_count;
`ifdef RADIO_XCVR_PARITY_EN
  logic              rx_par_bad;
`else
  assign err_parity = 1'b0;
`endif

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      rx_s1 <= IDLE_LEVEL;
      rx_s2 <= IDLE_LEVEL;
    end else begin
      rx_s1 <= rx_serial_data;
      rx_s2 <= rx_s1;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      rx_state    <= IDLE;
      rx_timer    <= '0;
      rx_bit      <= '0;
      rx_shift    <= '0;
      rx_wait     <= 1'b0;
      rx_count    <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      err_framing <= 1'b0;
      err_overrun <= 1'b0;
`ifdef RADIO_XCVR_PARITY_EN
      rx_par_bad  <= 1'b0;
      err_parity  <= 1'b0;
`endif
    end else begin
      err_framing <= 1'b0;
      err_overrun <= 1'b0;
`ifdef RADIO_XCVR_PARITY_EN
      err_parity  <= 1'b0;
`endif
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      case (rx_state)
        IDLE: begin
          if (rx_s2 == START_LEVEL) begin
            rx_state <= START;
            rx_timer <= HALF_LAST;
          end
        end
        START: begin
          if (rx_timer == '0) begin
            if (rx_s2 == START_LEVEL) begin
              rx_state <= DATA;
              rx_timer <= BIT_LAST;
              rx_bit   <= BIT_TOP;
            end else begin
              rx_state <= IDLE;
            end
          end else begin
            rx_timer <= rx_timer - 1'b1;
          end
        end
        DATA: begin
          if (rx_timer == '0) begin
            rx_shift <= {rx_s2, rx_shift[DATA_W-1:1]};
            rx_timer <= BIT_LAST;
            if (rx_bit == '0) begin
`ifdef RADIO_XCVR_PARITY_EN
              rx_state <= PARITY;
`else
              rx_state <= STOP;
`endif
            end else begin
              rx_bit <= rx_bit - 1'b1;
            end
          end else begin
            rx_timer <= rx_timer - 1'b1;
          end
        end
        PARITY: begin
          if (rx_timer == '0) begin
`ifdef RADIO_XCVR_PARITY_EN
            rx_par_bad <= (rx_s2 != ^rx_shift);
`endif
            rx_state <= STOP;
            rx_timer <= BIT_LAST;
          end else begin
            rx_timer <= rx_timer - 1'b1;
          end
        end
        STOP: begin
          // after a framing error, hold here until the line is released
          if (rx_wait) begin
            if (rx_s2 == IDLE_LEVEL) begin
              rx_wait  <= 1'b0;
              rx_state <= IDLE;
            end
          end else if (rx_timer == '0) begin
            if (rx_s2 != IDLE_LEVEL) begin
              err_framing <= 1'b1;
              rx_wait     <= 1'b1;
`ifdef RADIO_XCVR_PARITY_EN
            end else if (rx_par_bad) begin
              err_parity <= 1'b1;
              rx_state   <= IDLE;
`endif
            end else begin
              rx_state <= IDLE;
              if (!rx_valid || rx_ready) begin
                rx_data  <= rx_shift;
                rx_valid <= 1'b1;
                rx_count <= rx_count + 1'b1;
              end else begin
                err_overrun <= 1'b1;
              end
            end
          end else begin
            rx_timer <= rx_timer - 1'b1;
          end
        end
        default: rx_state <= IDLE;
      endcase
    end
  end

  assign led = {rx_count, (rx_state != IDLE), (tx_state != IDLE)};

endmodule

// File: tb/tb_radio_serial_xcvr.sv
// Self-checking bench for radio_serial_xcvr: frames are predicted bit-by-bit
// from the word value and the serial frame format.
module tb_radio_serial_xcvr;

  localparam int DW    = 8;
  localparam int CPB   = 16;
  localparam int DEPTH = 16;
  localparam int LW    = 8;
`ifdef RADIO_XCVR_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NBITS = DW + 2 + PB;
  localparam int FRAME = NBITS * CPB;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          tx_line;
  logic          rx_line;
  logic          err_framing;
  logic          err_overrun;
  logic          err_parity;
  logic [LW-1:0] led;

  logic          loop_en;
  logic          drv_line;
  logic [LW-3:0] exp_cnt;

  int checks = 0;
  int errors = 0;
  int n_fram = 0;
  int n_ovr  = 0;
  int n_par  = 0;

  always #5 clk = ~clk;

  assign rx_line = loop_en ? tx_line : drv_line;

  radio_serial_xcvr #(
    .DATA_W       (DW),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .LED_W        (LW)
  ) dut (
    .clk_clk        (clk),
    .reset_reset    (reset),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .tx_serial_data (tx_line),
    .rx_serial_data (rx_line),
    .err_framing    (err_framing),
    .err_overrun    (err_overrun),
    .err_parity     (err_parity),
    .led            (led)
  );

  always @(negedge clk) begin
    if (err_framing === 1'b1) n_fram++;
    if (err_overrun === 1'b1) n_ovr++;
    if (err_parity === 1'b1)  n_par++;
  end

  // Line level k cycles into a frame carrying word w.
  function automatic logic frame_level(input logic [DW-1:0] w, input int k);
    int b;
    b = k / CPB;
    if (b == 0) return 1'b0;
    if (b <= DW) return w[b-1];
    if (b == DW + 1 && b < NBITS - 1) return ^w;
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    exp_cnt = '0;
  endtask

  task automatic send_word(input logic [DW-1:0] w);
    int n;
    n = 0;
    while (tx_ready !== 1'b1 && n < 4 * FRAME) begin
      tick();
      n++;
    end
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready timeout: tx_ready=%b required 1", tx_ready);
    end
    tx_data  = w;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic wait_rx(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (rx_valid === 1'b1) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic drive_frame(input logic [DW-1:0] w, input logic stop_lvl, input logic par_flip);
    logic lvl;
    int   b;
    for (int k = 0; k < FRAME; k++) begin
      b   = k / CPB;
      lvl = frame_level(w, k);
      if (b == NBITS - 1) lvl = stop_lvl;
      if (b == DW + 1 && b < NBITS - 1) lvl = lvl ^ par_flip;
      drv_line = lvl;
      tick();
    end
    drv_line = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0;
    loop_en = 1'b0; drv_line = 1'b1; exp_cnt = '0;
    repeat (3) tick();
    checks++;
    if (tx_line !== 1'b1) begin errors++; $display("FAIL reset_line: got %b want 1", tx_line); end
    checks++;
    if (tx_ready !== 1'b0) begin errors++; $display("FAIL reset_tx_ready: got %b want 0", tx_ready); end
    checks++;
    if (rx_valid !== 1'b0 || rx_data !== '0) begin
      errors++; $display("FAIL reset_rx: rx_valid=%b rx_data=%h want 0/00", rx_valid, rx_data);
    end
    checks++;
    if ({err_framing, err_overrun, err_parity} !== 3'b000) begin
      errors++; $display("FAIL reset_err: got %b want 000", {err_framing, err_overrun, err_parity});
    end
    checks++;
    if (led !== '0) begin errors++; $display("FAIL reset_led: got %h want 00", led); end
    reset = 1'b0;
    checks++;
    if (tx_ready !== 1'b0) begin errors++; $display("FAIL ready_early: got %b want 0", tx_ready); end
    tick();
    checks++;
    if (tx_ready !== 1'b1) begin errors++; $display("FAIL ready_rise: got %b want 1", tx_ready); end
  endtask

  task automatic test_tx_frame();
    logic [DW-1:0] w;
    for (int n = 0; n < 4; n++) begin
      w = (n == 0) ? 8'hA5 : DW'($urandom);
      tx_data  = w;
      tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      checks++;
      if (tx_line !== 1'b1) begin errors++; $display("FAIL tx_latency: line=%b want 1 one cycle after write", tx_line); end
      tick();
      for (int k = 0; k < FRAME; k++) begin
        checks++;
        if (tx_line !== frame_level(w, k) || led[0] !== 1'b1) begin
          errors++;
          $display("FAIL tx_frame word=%h k=%0d: line=%b led0=%b want %b/1", w, k, tx_line, led[0], frame_level(w, k));
        end
        tick();
      end
      checks++;
      if (tx_line !== 1'b1 || led[0] !== 1'b0) begin
        errors++; $display("FAIL tx_idle: line=%b led0=%b want 1/0", tx_line, led[0]);
      end
    end
  endtask

  task automatic test_fifo_full();
    logic [DW-1:0] w [18];
    logic          want;
    for (int i = 0; i < 18; i++) w[i] = DW'($urandom);
    tx_data = w[0]; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tick();
    for (int k = 0; k < 17 * FRAME; k++) begin
      want = frame_level(w[k / FRAME], k % FRAME);
      checks++;
      if (tx_line !== want) begin
        errors++; $display("FAIL b2b_line k=%0d: got %b want %b", k, tx_line, want);
      end
      if (k >= 1 && k <= 17) begin
        checks++;
        if (tx_ready !== (k <= 16)) begin
          errors++; $display("FAIL fifo_ready k=%0d: got %b want %b", k, tx_ready, (k <= 16));
        end
        tx_data  = w[k];
        tx_valid = 1'b1;
      end else begin
        tx_valid = 1'b0;
      end
      tick();
    end
    tx_valid = 1'b0;
    for (int k = 0; k < FRAME; k++) begin
      checks++;
      if (tx_line !== 1'b1) begin errors++; $display("FAIL fifo_refused k=%0d: line=%b want 1", k, tx_line); end
      tick();
    end
    checks++;
    if (tx_ready !== 1'b1) begin errors++; $display("FAIL fifo_drained: tx_ready=%b want 1", tx_ready); end
  endtask

  task automatic test_rx_random();
    logic [DW-1:0] w;
    bit ok;
    loop_en = 1'b0;
    for (int n = 0; n < 4; n++) begin
      w = DW'($urandom);
      drive_frame(w, 1'b1, 1'b0);
      wait_rx(ok);
      exp_cnt = exp_cnt + 1'b1;
      checks++;
      if (!ok || rx_data !== w) begin
        errors++; $display("FAIL rx_word: valid=%b data=%h want 1/%h", rx_valid, rx_data, w);
      end
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
      checks++;
      if (rx_valid !== 1'b0 || led[LW-1:2] !== exp_cnt) begin
        errors++; $display("FAIL rx_consume: valid=%b count=%0d want 0/%0d", rx_valid, led[LW-1:2], exp_cnt);
      end
    end
  endtask

  task automatic test_loopback();
    logic [DW-1:0] w [3];
    int f0, o0;
    bit ok;
    w[0] = 8'h00; w[1] = 8'hFF; w[2] = 8'h3C;
    apply_reset();
    loop_en = 1'b1;
    f0 = n_fram; o0 = n_ovr;
    for (int i = 0; i < 3; i++) send_word(w[i]);
    for (int i = 0; i < 3; i++) begin
      wait_rx(ok);
      checks++;
      if (!ok || rx_data !== w[i]) begin
        errors++; $display("FAIL loop_word%0d: valid=%b data=%h want 1/%h", i, rx_valid, rx_data, w[i]);
      end
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
    end
    exp_cnt = 3;
    checks++;
    if (led[LW-1:2] !== exp_cnt) begin errors++; $display("FAIL loop_led: got %0d want 3", led[LW-1:2]); end
    checks++;
    if (n_fram != f0 || n_ovr != o0) begin
      errors++; $display("FAIL loop_errs: framing=%0d overrun=%0d want 0/0", n_fram - f0, n_ovr - o0);
    end
    repeat (FRAME) tick();
  endtask

  task automatic test_overrun();
    logic [DW-1:0] w0, w1;
    int o0;
    w0 = DW'($urandom); w1 = DW'($urandom);
    loop_en = 1'b1; rx_ready = 1'b0;
    o0 = n_ovr;
    send_word(w0);
    send_word(w1);
    repeat (2 * FRAME + 2 * CPB) tick();
    exp_cnt = exp_cnt + 1'b1;
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== w0) begin
      errors++; $display("FAIL ovr_keep: valid=%b data=%h want 1/%h", rx_valid, rx_data, w0);
    end
    checks++;
    if (n_ovr - o0 != 1) begin errors++; $display("FAIL ovr_pulse: got %0d pulses want 1", n_ovr - o0); end
    checks++;
    if (led[LW-1:2] !== exp_cnt) begin errors++; $display("FAIL ovr_led: got %0d want %0d", led[LW-1:2], exp_cnt); end
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  task automatic test_framing();
    logic [DW-1:0] w;
    int f0, o0;
    bit ok;
    loop_en = 1'b0;
    f0 = n_fram;
    w = DW'($urandom);
    drive_frame(w, 1'b0, 1'b0);
    repeat (CPB) tick();
    checks++;
    if (n_fram - f0 != 1 || rx_valid !== 1'b0) begin
      errors++; $display("FAIL framing: pulses=%0d valid=%b want 1/0", n_fram - f0, rx_valid);
    end
    checks++;
    if (led[1] !== 1'b0) begin errors++; $display("FAIL framing_idle: led1=%b want 0", led[1]); end
    w = DW'($urandom);
    drive_frame(w, 1'b1, 1'b0);
    wait_rx(ok);
    exp_cnt = exp_cnt + 1'b1;
    checks++;
    if (!ok || rx_data !== w) begin
      errors++; $display("FAIL framing_recover: valid=%b data=%h want 1/%h", rx_valid, rx_data, w);
    end
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    f0 = n_fram; o0 = n_ovr;
    drv_line = 1'b0;
    repeat (3) tick();
    drv_line = 1'b1;
    repeat (2 * CPB) tick();
    checks++;
    if (rx_valid !== 1'b0 || n_fram != f0 || n_ovr != o0 || led[LW-1:1] !== {exp_cnt, 1'b0}) begin
      errors++; $display("FAIL glitch: valid=%b framing=%0d overrun=%0d led=%h want no response",
                         rx_valid, n_fram - f0, n_ovr - o0, led);
    end
  endtask

  task automatic test_reset_mid();
    loop_en = 1'b1; rx_ready = 1'b0;
    send_word(DW'($urandom));
    repeat (1 + 3 * CPB) tick();
    checks++;
    if (led[1:0] !== 2'b11) begin errors++; $display("FAIL mid_busy: led=%b want 11", led[1:0]); end
    reset = 1'b1;
    tick();
    checks++;
    if (tx_line !== 1'b1 || tx_ready !== 1'b0) begin
      errors++; $display("FAIL mid_reset: line=%b ready=%b want 1/0", tx_line, tx_ready);
    end
    tick();
    reset = 1'b0;
    tick();
    exp_cnt = '0;
    checks++;
    if (tx_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b want 1", tx_ready); end
    for (int k = 0; k < FRAME + CPB; k++) begin
      checks++;
      if (tx_line !== 1'b1 || rx_valid !== 1'b0) begin
        errors++; $display("FAIL mid_quiet k=%0d: line=%b valid=%b want 1/0", k, tx_line, rx_valid);
      end
      tick();
    end
    checks++;
    if (led !== '0) begin errors++; $display("FAIL mid_led: got %h want 00", led); end
  endtask

`ifdef RADIO_XCVR_PARITY_EN
  task automatic test_parity();
    logic [DW-1:0] w;
    int p0;
    bit ok;
    loop_en = 1'b0;
    p0 = n_par;
    w = DW'($urandom);
    drive_frame(w, 1'b1, 1'b1);
    repeat (CPB) tick();
    checks++;
    if (n_par - p0 != 1 || rx_valid !== 1'b0) begin
      errors++; $display("FAIL parity_bad: pulses=%0d valid=%b want 1/0", n_par - p0, rx_valid);
    end
    w = DW'($urandom);
    drive_frame(w, 1'b1, 1'b0);
    wait_rx(ok);
    checks++;
    if (!ok || rx_data !== w || n_par - p0 != 1) begin
      errors++; $display("FAIL parity_good: valid=%b data=%h pulses=%0d want 1/%h/1", rx_valid, rx_data, n_par - p0, w);
    end
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_tx_frame();
    test_fifo_full();
    test_rx_random();
    test_loopback();
    test_overrun();
    test_framing();
    test_reset_mid();
`ifdef RADIO_XCVR_PARITY_EN
    test_parity();
`else
    checks++;
    if (n_par != 0) begin errors++; $display("FAIL parity_tied: got %0d pulses want 0", n_par); end
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
